// File: rtl/featuremap_conv3x3_nch_if.sv
// Bus bundle for featuremap_conv3x3_nch.
//   master : the side that drives start, weight writes and the pixel FIFO
//            (data_in / data_fifo_empty). It receives rdreq, data_out,
//            valid_out, frame_done and busy.
//   slave  : the convolution block.
// wr_addr selects a tap as ch*9 + row*3 + col. Address 9*CH selects the bias.
interface featuremap_conv3x3_nch_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH         = 3
) ();
    localparam int ADDR_W = $clog2(9 * CH + 1);

    logic                       start;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic [DATA_WIDTH*CH-1:0]   data_in;
    logic                       data_fifo_empty;
    logic                       rdreq;
    logic [DATA_WIDTH-1:0]      data_out;
    logic                       valid_out;
    logic                       frame_done;
    logic                       busy;

    modport master (
        output start, wr_en, wr_addr, wr_data, data_in, data_fifo_empty,
        input  rdreq, data_out, valid_out, frame_done, busy
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_data, data_in, data_fifo_empty,
        output rdreq, data_out, valid_out, frame_done, busy
    );
endinterface

// File: rtl/featuremap_conv3x3_nch.sv
// 3x3 signed fixed-point convolution of a CH-channel, pre-padded frame into
// one output feature map. Per-channel line buffers build the window. The
// 9*CH products are summed with the bias, then scaled back, optionally
// passed through ReLU, and saturated.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of featuremap_conv3x3_nch_if. It carries
//              start/weights, the pixel FIFO (show-ahead, read with rdreq)
//              and the result stream (data_out/valid_out, frame_done, busy).
// The result appears 3 cycles after the read that completes a window.
module featuremap_conv3x3_nch #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int CH         = 3,
    parameter int WIDTH      = 114,
    parameter int HEIGHT     = 114,
    parameter int STRIDE     = 1,
    parameter int RELU_EN    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    featuremap_conv3x3_nch_if.slave bus
);
    localparam int DW     = DATA_WIDTH;
    localparam int NTAP   = 9 * CH;
    localparam int ADDR_W = $clog2(NTAP + 1);
    localparam int PW     = 2 * DW;
    localparam int ACC_W  = PW + $clog2(NTAP);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int COL_W  = $clog2(WIDTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [ROW_W-1:0]         row;
    logic [COL_W-1:0]         col;
    logic [1:0]               drain_cnt;
    logic                     rd, done, last_px, win_ok;
    logic [2:0]               vld_pipe;   // S1, S2, S3 valid

    logic signed [DW-1:0]     wgt [NTAP];
    logic signed [DW-1:0]     bias;
    logic signed [DW-1:0]     lb1 [CH][WIDTH];   // previous row
    logic signed [DW-1:0]     lb2 [CH][WIDTH];   // row before that
    logic signed [DW-1:0]     win [CH][3][3];    // [ch][row][col], col 2 newest
    logic signed [DW-1:0]     nwin [CH][3][3];
    logic signed [PW-1:0]     prod [NTAP];
    logic signed [ACC_W-1:0]  sum, acc, shifted, clipped;
    logic [DW-1:0]            data_out;

    assign last_px = (row == ROW_W'(HEIGHT - 1)) && (col == COL_W'(WIDTH - 1));
    // With stride 2 only windows whose top-left is at an even offset are
    // used. (row-2) is even exactly when row is even.
    assign win_ok  = (row >= ROW_W'(2)) && (col >= COL_W'(2)) &&
                     ((STRIDE == 1) || (!row[0] && !col[0]));

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = RUN;
            RUN: begin
                rd = !bus.data_fifo_empty;
                if (rd && last_px) state_nxt = DRAIN;
            end
            DRAIN: if (drain_cnt == 2'd2) begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
            vld_pipe  <= '0;
            data_out  <= '0;
            bias      <= '0;
            for (int i = 0; i < NTAP; i++) wgt[i] <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state == IDLE && bus.start) begin
                row <= '0;
                col <= '0;
            end else if (rd) begin
                if (col == COL_W'(WIDTH - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == IDLE && bus.wr_en) begin
                if (bus.wr_addr == ADDR_W'(NTAP))      bias <= bus.wr_data;
                else if (bus.wr_addr < ADDR_W'(NTAP))  wgt[bus.wr_addr] <= bus.wr_data;
            end
            vld_pipe <= {vld_pipe[1:0], rd && win_ok};
            if (vld_pipe[1]) data_out <= clipped[DW-1:0];
        end
    end

    // This is the window as it will look after the current read. Feeding the
    // multipliers from it directly keeps the latency at 3.
    always_comb begin
        for (int ch = 0; ch < CH; ch++) begin
            for (int r = 0; r < 3; r++) begin
                nwin[ch][r][0] = win[ch][r][1];
                nwin[ch][r][1] = win[ch][r][2];
            end
            nwin[ch][0][2] = lb2[ch][col];
            nwin[ch][1][2] = lb1[ch][col];
            nwin[ch][2][2] = bus.data_in[ch*DW +: DW];
        end
    end

    // Datapath: no reset needed, validity is tracked by vld_pipe.
    always_ff @(posedge clk) begin
        if (rd) begin
            win <= nwin;
            for (int ch = 0; ch < CH; ch++) begin
                lb2[ch][col] <= lb1[ch][col];
                lb1[ch][col] <= bus.data_in[ch*DW +: DW];
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        prod[ch*9 + r*3 + c] <= PW'(nwin[ch][r][c]) * PW'(wgt[ch*9 + r*3 + c]);
            end
        end
        if (vld_pipe[0]) acc <= sum;
    end

    always_comb begin
        sum = ACC_W'(bias) <<< FRAC_BITS;
        for (int i = 0; i < NTAP; i++) sum = sum + ACC_W'(prod[i]);
    end

    always_comb begin
        shifted = acc >>> FRAC_BITS;   // floor
        clipped = shifted;
        if (RELU_EN != 0 && shifted < 0) clipped = '0;
        if (clipped > SAT_MAX)      clipped = SAT_MAX;
        else if (clipped < SAT_MIN) clipped = SAT_MIN;
    end

    assign bus.rdreq      = rd;
    assign bus.data_out   = data_out;
    assign bus.valid_out  = vld_pipe[2];
    assign bus.frame_done = done;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_featuremap_conv3x3_nch.sv
// Bench for featuremap_conv3x3_nch. It runs three instances on the same
// stimulus:
//   a: stride 1, ReLU on
//   b: stride 2, ReLU on
//   c: stride 1, ReLU off
// A plain-arithmetic model of the convolution supplies the expected values.
module tb_featuremap_conv3x3_nch;
    localparam int DW = 16, CH = 3, W = 6, H = 6, NT = 9 * CH, NPIX = W * H;
    localparam int AW = $clog2(NT + 1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_en = 1'b0, empty = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic [DW*CH-1:0] data_in = '0;

    int nchk = 0, nfail = 0;
    int cyc = 0, last_rd = 0, fd_cyc = 0, fd_cnt = 0, viol = 0;
    int qa[$], qb[$], qc[$], ea[$], eb[$], ec[$], ng[$];
    int wm [NT+1];
    logic signed [DW-1:0] pix [CH][H][W];

    featuremap_conv3x3_nch_if #(.DATA_WIDTH(DW), .CH(CH)) ifa ();
    featuremap_conv3x3_nch_if #(.DATA_WIDTH(DW), .CH(CH)) ifb ();
    featuremap_conv3x3_nch_if #(.DATA_WIDTH(DW), .CH(CH)) ifc ();

    assign ifa.start = start;  assign ifa.wr_en = wr_en;  assign ifa.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data;  assign ifa.data_in = data_in;  assign ifa.data_fifo_empty = empty;
    assign ifb.start = start;  assign ifb.wr_en = wr_en;  assign ifb.wr_addr = wr_addr;
    assign ifb.wr_data = wr_data;  assign ifb.data_in = data_in;  assign ifb.data_fifo_empty = empty;
    assign ifc.start = start;  assign ifc.wr_en = wr_en;  assign ifc.wr_addr = wr_addr;
    assign ifc.wr_data = wr_data;  assign ifc.data_in = data_in;  assign ifc.data_fifo_empty = empty;

    featuremap_conv3x3_nch #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CH(CH), .WIDTH(W), .HEIGHT(H),
        .STRIDE(1), .RELU_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    featuremap_conv3x3_nch #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CH(CH), .WIDTH(W), .HEIGHT(H),
        .STRIDE(2), .RELU_EN(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    featuremap_conv3x3_nch #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CH(CH), .WIDTH(W), .HEIGHT(H),
        .STRIDE(1), .RELU_EN(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector: samples 2 time units after the falling edge.
    always begin
        @(negedge clk);
        #2;
        if (start) begin
            qa.delete(); qb.delete(); qc.delete();
            fd_cnt = 0;
            viol   = 0;
        end
        if (ifa.valid_out) qa.push_back(int'($signed(ifa.data_out)));
        if (ifb.valid_out) qb.push_back(int'($signed(ifb.data_out)));
        if (ifc.valid_out) qc.push_back(int'($signed(ifc.data_out)));
        if (ifa.frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (ifa.rdreq && empty) viol++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, got[i], exp[i]);
    endtask

    task automatic wr(input int a, input int d, input bit upd);
        logic signed [DW-1:0] v;
        v = d[DW-1:0];
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        if (upd) wm[a] = int'(v);
    endtask

    task automatic load_const(input int w, input int b);
        for (int i = 0; i < NT; i++) wr(i, w, 1'b1);
        wr(NT, b, 1'b1);
    endtask

    task automatic load_rand();
        for (int i = 0; i < NT; i++) wr(i, int'($urandom_range(0, 128)) - 64, 1'b1);
        wr(NT, int'($urandom_range(0, 2048)) - 1024, 1'b1);
    endtask

    // mode 0: identity pattern, 1: every pixel = v, 2: random
    task automatic set_pix(input int mode, input int v);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    int p;
                    if (mode == 0)      p = (ch == 0) ? ((r * W + c) << 8) : 32'h7FFF;
                    else if (mode == 1) p = v;
                    else                p = int'($urandom);
                    pix[ch][r][c] = p[DW-1:0];
                end
    endtask

    function automatic int ref_px(int i, int j, bit relu);
        longint acc, q;
        acc = longint'(wm[NT]) * 256;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    acc += longint'(pix[ch][i+r][j+c]) * longint'(wm[ch*9 + r*3 + c]);
        q = acc / 256;
        if (acc % 256 != 0 && acc < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic void build_exp();
        ea.delete(); eb.delete(); ec.delete();
        for (int i = 0; i < H - 2; i++)
            for (int j = 0; j < W - 2; j++) begin
                ea.push_back(ref_px(i, j, 1'b1));
                ec.push_back(ref_px(i, j, 1'b0));
                if (i % 2 == 0 && j % 2 == 0) eb.push_back(ref_px(i, j, 1'b1));
            end
    endfunction

    task automatic check_all(input string tag);
        cmp_q({tag, "_a"}, qa, ea);
        cmp_q({tag, "_b"}, qb, eb);
        cmp_q({tag, "_c"}, qc, ec);
    endtask

    // One frame through the pixel FIFO model. wr_at pulses a weight write
    // while that pixel is offered. rst_at aborts the frame with a reset at
    // that pixel.
    task automatic run_frame(input string tag, input bit gaps, input int wr_at, input int rst_at);
        int idx, budget, sz;
        bit r;
        idx = 0;
        budget = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (idx < NPIX && budget < 4000) begin
            for (int ch = 0; ch < CH; ch++) data_in[ch*DW +: DW] = pix[ch][idx / W][idx % W];
            empty   = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_en   = (idx == wr_at);
            wr_addr = AW'(4);
            wr_data = 16'h0100;
            if (idx == rst_at) begin
                rst = 1'b1; empty = 1'b0;
                @(negedge clk);
                rst = 1'b0; wr_en = 1'b0;
                #2;
                chk({tag, "_valid_out"},  ifa.valid_out, 0);
                chk({tag, "_data_out"},   ifa.data_out, 0);
                chk({tag, "_frame_done"}, ifa.frame_done, 0);
                chk({tag, "_busy"},       ifa.busy, 0);
                chk({tag, "_rdreq"},      ifa.rdreq, 0);
                sz = qa.size();
                repeat (6) @(negedge clk);
                #2;
                chk({tag, "_no_late_out"}, qa.size(), sz);
                chk({tag, "_no_done"},     fd_cnt, 0);
                return;
            end
            #1 r = ifa.rdreq;
            if (r) begin
                last_rd = cyc;
                idx++;
            end
            @(negedge clk);
            budget++;
        end
        wr_en = 1'b0;
        empty = 1'b1;
        chk({tag, "_reads"}, idx, NPIX);
        repeat (8) @(negedge clk);
        #2;
        chk({tag, "_done_count"},   fd_cnt, 1);
        chk({tag, "_done_latency"}, fd_cyc - last_rd, 3);
        chk({tag, "_idle_busy"},    ifa.busy, 0);
    endtask

    initial begin
        for (int i = 0; i <= NT; i++) wm[i] = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_valid_a", ifa.valid_out, 0);
        chk("rst_data_a",  ifa.data_out, 0);
        chk("rst_done_a",  ifa.frame_done, 0);
        chk("rst_busy_a",  ifa.busy, 0);
        chk("rst_rdreq_a", ifa.rdreq, 0);
        chk("rst_valid_b", ifb.valid_out, 0);
        chk("rst_busy_c",  ifc.busy, 0);

        // Identity: centre tap of channel 0 only
        load_const(0, 0);
        wr(4, 256, 1'b1);
        set_pix(0, 0);
        build_exp();
        run_frame("id", 1'b0, -1, -1);
        check_all("id");
        chk("id_n16",    qa.size(), 16);
        chk("id_first",  (qa.size() > 0) ? qa[0] : -1, 7 << 8);
        chk("id_last",   (qa.size() > 15) ? qa[15] : -1, 28 << 8);
        chk("s2_n4",     qb.size(), 4);
        chk("s2_second", (qb.size() > 1) ? qb[1] : -1, 9 << 8);
        chk("s2_last",   (qb.size() > 3) ? qb[3] : -1, 21 << 8);

        // Positive saturation
        load_const(32'h7FFF, 0);
        set_pix(1, 32'h7FFF);
        build_exp();
        run_frame("satp", 1'b0, -1, -1);
        check_all("satp");
        chk("satp_val", (qa.size() > 0) ? qa[0] : 0, 32767);

        // Negative saturation and ReLU
        set_pix(1, 32'h8000);
        build_exp();
        run_frame("satn", 1'b0, -1, -1);
        check_all("satn");
        chk("satn_relu",   (qa.size() > 0) ? qa[0] : -1, 0);
        chk("satn_norelu", (qc.size() > 0) ? qc[0] : 0, -32768);

        // Bias only
        load_const(0, 32'h0180);
        set_pix(2, 0);
        build_exp();
        run_frame("bias", 1'b0, -1, -1);
        check_all("bias");
        chk("bias_val", (qc.size() > 0) ? qc[0] : 0, 32'h0180);

        // Random data, first without and then with FIFO gaps
        load_rand();
        set_pix(2, 0);
        build_exp();
        run_frame("rnd", 1'b0, -1, -1);
        check_all("rnd");
        ng = qa;
        run_frame("gap", 1'b1, -1, -1);
        check_all("gap");
        cmp_q("gap_vs_nogap", qa, ng);
        chk("gap_rd_empty", viol, 0);

        // Weight write during RUN is ignored. The same write in IDLE applies.
        load_rand();
        wr(4, 0, 1'b1);
        set_pix(2, 0);
        build_exp();
        run_frame("runwr", 1'b0, 10, -1);
        check_all("runwr");
        wr(4, 32'h0100, 1'b1);
        build_exp();
        run_frame("idlewr", 1'b0, -1, -1);
        check_all("idlewr");

        // Reset mid-frame, then weights must read back as zero
        load_const(0, 0);
        wr(4, 256, 1'b1);
        set_pix(0, 0);
        run_frame("midrst", 1'b0, -1, 20);
        for (int i = 0; i <= NT; i++) wm[i] = 0;
        build_exp();
        run_frame("zerow", 1'b0, -1, -1);
        check_all("zerow");
        load_const(0, 0);
        wr(4, 256, 1'b1);
        build_exp();
        run_frame("after_rst", 1'b0, -1, -1);
        check_all("after_rst");
        chk("after_rst_n16", qa.size(), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
